dsp_mac_pipe: RTL

- Parametrised, pipelined multiply-accumulate datapath; successor to the fixed 20x18/38-bit DSP primitive used in the DSP logical tile.
- Adds configurable operand and accumulator widths, multiple time-multiplexed accumulator channels, a valid/channel tag through the pipe, and a per-sample saturation flag.
- Sits inside the DSP tile as the compute core. Mode bits still come from the configuration chain; this block sees only per-sample control inputs.

---
 rtl/dsp_mac_pipe.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/dsp_mac_pipe.sv
// Pipelined multiply-accumulate core with NUM_CH time-multiplexed accumulators.
// Four stages: operand capture, product, accumulate/saturate, round/shift output.
module dsp_mac_pipe #(
    parameter  int A_WIDTH     = 20,
    parameter  int B_WIDTH     = 18,
    parameter  int ACC_WIDTH   = 38,
    parameter  int SHIFT_WIDTH = 6,
    parameter  int NUM_CH      = 2,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   valid_i,
    input  logic [CH_W-1:0]        ch_i,
    input  logic [A_WIDTH-1:0]     a_i,
    input  logic [B_WIDTH-1:0]     b_i,
    input  logic                   unsigned_a,
    input  logic                   unsigned_b,
    input  logic                   load_acc,
    input  logic                   subtract,
    input  logic                   saturate_enable,
    input  logic [SHIFT_WIDTH-1:0] shift_right,
    input  logic                   round,
    output logic                   valid_o,
    output logic [CH_W-1:0]        ch_o,
    output logic [ACC_WIDTH-1:0]   z_o,
    output logic                   sat_o,
    output logic [B_WIDTH-1:0]     dly_b_o
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH + 2;
    // Wide enough that base +/- product is always exact, so overflow is a plain range test.
    localparam int W_WIDTH = ((P_WIDTH > ACC_WIDTH) ? P_WIDTH : ACC_WIDTH) + 2;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // S1 registers
    logic                   r_v1;
    logic [CH_W-1:0]        r_ch1;
    logic [A_WIDTH-1:0]     r_a1;
    logic [B_WIDTH-1:0]     r_b1;
    logic                   r_ua1;
    logic                   r_ub1;
    logic                   r_load1;
    logic                   r_sub1;
    logic                   r_sate1;
    logic [SHIFT_WIDTH-1:0] r_shift1;
    logic                   r_round1;

    // S2 registers
    logic                   r_v2;
    logic [CH_W-1:0]        r_ch2;
    logic [P_WIDTH-1:0]     r_p2;
    logic                   r_load2;
    logic                   r_sub2;
    logic                   r_sate2;
    logic [SHIFT_WIDTH-1:0] r_shift2;
    logic                   r_round2;

    // S3 registers
    logic                   r_v3;
    logic [CH_W-1:0]        r_ch3;
    logic [ACC_WIDTH-1:0]   r_acc3;
    logic                   r_sat3;
    logic                   r_sate3;
    logic [SHIFT_WIDTH-1:0] r_shift3;
    logic                   r_round3;

    logic [ACC_WIDTH-1:0]   r_acc [NUM_CH];

    logic                   w_ch_ok;
    logic [P_WIDTH-1:0]     w_a_x;
    logic [P_WIDTH-1:0]     w_b_x;
    logic [P_WIDTH-1:0]     w_prod;

    logic [ACC_WIDTH-1:0]   w_acc_rd;
    logic [W_WIDTH-1:0]     w_p_wide;
    logic [W_WIDTH-1:0]     w_base;
    logic [W_WIDTH-1:0]     w_sum;
    logic                   w_p_ovf;
    logic                   w_sum_ovf;
    logic                   w_ovf;
    logic [ACC_WIDTH-1:0]   w_acc_new;
    logic                   w_sat_new;

    logic                   w_shift_big;
    logic [ACC_WIDTH:0]     w_half;
    logic [ACC_WIDTH:0]     w_rnd;
    logic                   w_rnd_ovf;
    logic signed [ACC_WIDTH-1:0] w_rsat;
    logic signed [ACC_WIDTH-1:0] w_shr;
    logic [ACC_WIDTH-1:0]   w_z;

    // ---------------- S1: capture ----------------
    assign w_ch_ok = (32'(ch_i) < NUM_CH);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v1     <= 1'b0;
            r_ch1    <= '0;
            r_a1     <= '0;
            r_b1     <= '0;
            r_ua1    <= 1'b0;
            r_ub1    <= 1'b0;
            r_load1  <= 1'b0;
            r_sub1   <= 1'b0;
            r_sate1  <= 1'b0;
            r_shift1 <= '0;
            r_round1 <= 1'b0;
        end else begin
            r_v1     <= valid_i && w_ch_ok;
            r_ch1    <= ch_i;
            r_a1     <= a_i;
            r_b1     <= b_i;
            r_ua1    <= unsigned_a;
            r_ub1    <= unsigned_b;
            r_load1  <= load_acc;
            r_sub1   <= subtract;
            r_sate1  <= saturate_enable;
            r_shift1 <= shift_right;
            r_round1 <= round;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dly_b_o <= '0;
        end else if (valid_i) begin
            dly_b_o <= b_i;
        end
    end

    // ---------------- S2: product ----------------
    // Both operands taken to the full product width; low P bits of the product are exact.
    assign w_a_x  = {{(P_WIDTH-A_WIDTH){~r_ua1 & r_a1[A_WIDTH-1]}}, r_a1};
    assign w_b_x  = {{(P_WIDTH-B_WIDTH){~r_ub1 & r_b1[B_WIDTH-1]}}, r_b1};
    assign w_prod = w_a_x * w_b_x;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v2     <= 1'b0;
            r_ch2    <= '0;
            r_p2     <= '0;
            r_load2  <= 1'b0;
            r_sub2   <= 1'b0;
            r_sate2  <= 1'b0;
            r_shift2 <= '0;
            r_round2 <= 1'b0;
        end else begin
            r_v2     <= r_v1;
            r_ch2    <= r_ch1;
            r_p2     <= w_prod;
            r_load2  <= r_load1;
            r_sub2   <= r_sub1;
            r_sate2  <= r_sate1;
            r_shift2 <= r_shift1;
            r_round2 <= r_round1;
        end
    end

    // ---------------- S3: accumulate ----------------
    assign w_acc_rd = r_acc[r_ch2];
    assign w_p_wide = {{(W_WIDTH-P_WIDTH){r_p2[P_WIDTH-1]}}, r_p2};
    assign w_base   = r_load2 ? '0 : {{(W_WIDTH-ACC_WIDTH){w_acc_rd[ACC_WIDTH-1]}}, w_acc_rd};
    assign w_sum    = r_sub2 ? (w_base - w_p_wide) : (w_base + w_p_wide);

    // In range iff every bit from the accumulator sign bit upward agrees.
    assign w_p_ovf   = !((&w_p_wide[W_WIDTH-1:ACC_WIDTH-1]) || !(|w_p_wide[W_WIDTH-1:ACC_WIDTH-1]));
    assign w_sum_ovf = !((&w_sum[W_WIDTH-1:ACC_WIDTH-1]) || !(|w_sum[W_WIDTH-1:ACC_WIDTH-1]));
    assign w_ovf     = w_p_ovf | w_sum_ovf;

    assign w_acc_new = (w_ovf && r_sate2) ? (w_sum[W_WIDTH-1] ? ACC_MIN : ACC_MAX)
                                          : w_sum[ACC_WIDTH-1:0];
    assign w_sat_new = w_ovf & r_sate2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
            end
        end else if (r_v2) begin
            r_acc[r_ch2] <= w_acc_new;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v3     <= 1'b0;
            r_ch3    <= '0;
            r_acc3   <= '0;
            r_sat3   <= 1'b0;
            r_sate3  <= 1'b0;
            r_shift3 <= '0;
            r_round3 <= 1'b0;
        end else begin
            r_v3     <= r_v2;
            r_ch3    <= r_ch2;
            r_acc3   <= w_acc_new;
            r_sat3   <= w_sat_new;
            r_sate3  <= r_sate2;
            r_shift3 <= r_shift2;
            r_round3 <= r_round2;
        end
    end

    // ---------------- S4: round, shift, output ----------------
    // Shifts of the full width or more collapse to the sign fill, so no rounding is applied.
    assign w_shift_big = (32'(r_shift3) >= ACC_WIDTH);
    assign w_half      = (r_round3 && (r_shift3 != '0) && !w_shift_big)
                         ? ({{ACC_WIDTH{1'b0}}, 1'b1} << (r_shift3 - SHIFT_WIDTH'(1)))
                         : '0;
    assign w_rnd       = {r_acc3[ACC_WIDTH-1], r_acc3} + w_half;
    assign w_rnd_ovf   = w_rnd[ACC_WIDTH] ^ w_rnd[ACC_WIDTH-1];
    assign w_rsat      = (w_rnd_ovf && r_sate3) ? ACC_MAX : w_rnd[ACC_WIDTH-1:0];
    assign w_shr       = w_rsat >>> r_shift3;
    assign w_z         = w_shift_big ? {ACC_WIDTH{r_acc3[ACC_WIDTH-1]}} : w_shr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_o <= 1'b0;
            ch_o    <= '0;
            z_o     <= '0;
            sat_o   <= 1'b0;
        end else begin
            valid_o <= r_v3;
            if (r_v3) begin
                ch_o  <= r_ch3;
                z_o   <= w_z;
                sat_o <= r_sat3 | (w_rnd_ovf & r_sate3);
            end
        end
    end

endmodule
